// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave responder.
// Holds the controller state enum and the default word width / idle TX pattern.
package spi_slv_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

    localparam int         SPI_WORD_W     = 8;
    localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

endpackage

// File: rtl/spi_slv_sync.sv
// Multi-flop pin synchronizer with registered rise/fall detection.
// The edge pulses line up one cycle after the synchronized level changes.
module spi_slv_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign sync = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, MOSI deserializer and buffered MISO serializer.
// Define SPI_SLV_MISO_TRISTATE_EN to release MISO to 'z while the slave is deselected.
module spi_slave_responder
    import spi_slv_pkg::*;
#(
    parameter int                WORD_W      = SPI_WORD_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] DEFAULT_TX  = WORD_W'(SPI_DEFAULT_TX)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    input  logic              i_TX_DV,
    input  logic [WORD_W-1:0] i_TX_Byte,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Byte
);

    localparam int               CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic spi_clk_sync, spi_clk_rise, spi_clk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .din   (i_SPI_Clk),
        .sync  (spi_clk_sync),
        .rise  (spi_clk_rise),
        .fall  (spi_clk_fall)
    );

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .din   (i_SPI_CS_n),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .din   (i_SPI_MOSI),
        .sync  (mosi_sync),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{spi_clk_sync, cs_sync, mosi_rise, mosi_fall};

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_shift;
    logic [WORD_W-1:0] tx_shift;
    logic [WORD_W-1:0] tx_buf;
    logic              tx_full;
    logic [WORD_W-1:0] rx_next;

    assign rx_next = {rx_shift[WORD_W-2:0], mosi_sync};

    // A word-boundary load drains the buffer; its clear of tx_full wins over a
    // same-cycle write, which was refused anyway because ready was low.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= DEFAULT_TX;
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= '0;
        end else begin
            o_RX_DV <= 1'b0;

            if (i_TX_DV && !tx_full) begin
                tx_buf  <= i_TX_Byte;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        tx_shift <= tx_full ? tx_buf : DEFAULT_TX;
                        if (tx_full) begin
                            tx_full <= 1'b0;
                        end
                    end
                end

                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (spi_clk_rise) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            o_RX_Byte <= rx_next;
                            o_RX_DV   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (spi_clk_fall) begin
                        if (bit_cnt == '0) begin
                            tx_shift <= tx_full ? tx_buf : DEFAULT_TX;
                            if (tx_full) begin
                                tx_full <= 1'b0;
                            end
                        end else begin
                            tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_TX_Ready = ~tx_full;

`ifdef SPI_SLV_MISO_TRISTATE_EN
    assign o_SPI_MISO = (state == ACTIVE && !cs_sync) ? tx_shift[WORD_W-1] : 1'bz;
`else
    assign o_SPI_MISO = tx_shift[WORD_W-1];
`endif

endmodule
